// File: rtl/core_inst_seq_if.sv
// Host/core-facing bundle of the instruction sequencer: job configuration and
// start in, 34-bit inst word plus job status out.
interface core_inst_seq_if #(
    parameter int addr_w = 11
);
    logic                 start;
    logic [3:0]           cfg_n_kij;
    logic [addr_w-1:0]    cfg_n_act;
    logic [addr_w-1:0]    cfg_w_base;
    logic [addr_w-1:0]    cfg_x_base;
    logic [addr_w-1:0]    cfg_p_base;
    logic                 ofifo_valid;
    logic [2*addr_w+11:0] inst;
    logic                 busy;
    logic                 done;
    logic [2:0]           phase;

    modport master (
        output start, cfg_n_kij, cfg_n_act, cfg_w_base, cfg_x_base, cfg_p_base, ofifo_valid,
        input  inst, busy, done, phase
    );

    modport slave (
        input  start, cfg_n_kij, cfg_n_act, cfg_w_base, cfg_x_base, cfg_p_base, ofifo_valid,
        output inst, busy, done, phase
    );
endinterface

// File: rtl/core_inst_seq.sv
// Instruction sequencer for the core datapath: per job, runs n_kij passes of
// weight fetch/load, activation fetch, execute+flush and OFIFO drain to PSUM SRAM.
module core_inst_seq #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int addr_w = 11,
    parameter int flush  = row + col
) (
    input logic            clk,
    input logic            reset_n,
    core_inst_seq_if.slave bus
);
    localparam int CNT_W = addr_w + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WFETCH = 3'd1;
    localparam logic [2:0] S_WLOAD  = 3'd2;
    localparam logic [2:0] S_XFETCH = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;
    localparam logic [2:0] S_FIN    = 3'd6;

    typedef struct packed {
        logic              acc;
        logic              cen_pmem;
        logic              wen_pmem;
        logic [addr_w-1:0] a_pmem;
        logic              cen_xmem;
        logic              wen_xmem;
        logic [addr_w-1:0] a_xmem;
        logic              ofifo_rd;
        logic              ififo_wr;
        logic              ififo_rd;
        logic              l0_rd;
        logic              l0_wr;
        logic              execute;
        logic              load;
    } inst_t;

    localparam inst_t IDLE_INST = '{
        acc:      1'b0,
        cen_pmem: 1'b1,
        wen_pmem: 1'b1,
        a_pmem:   '0,
        cen_xmem: 1'b1,
        wen_xmem: 1'b1,
        a_xmem:   '0,
        ofifo_rd: 1'b0,
        ififo_wr: 1'b0,
        ififo_rd: 1'b0,
        l0_rd:    1'b0,
        l0_wr:    1'b0,
        execute:  1'b0,
        load:     1'b0
    };

    logic [2:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [addr_w-1:0] k_q,      k_d;
    logic [3:0]        kij_q,    kij_d;
    logic [addr_w-1:0] w_off_q,  w_off_d;
    logic [addr_w-1:0] p_off_q,  p_off_d;
    logic [3:0]        n_kij_q,  n_kij_d;
    logic [addr_w-1:0] n_act_q,  n_act_d;
    logic [addr_w-1:0] w_base_q, w_base_d;
    logic [addr_w-1:0] x_base_q, x_base_d;
    logic [addr_w-1:0] p_base_q, p_base_d;
    inst_t             inst_q,   inst_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic              drain_wr;
    logic [CNT_W-1:0]  exec_last;

    assign exec_last = {1'b0, n_act_q} + CNT_W'(flush - 1);

    // Next-state logic; inst_d below is built from the *next* state so every
    // output is a plain flop aligned with phase.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        kij_d    = kij_q;
        w_off_d  = w_off_q;
        p_off_d  = p_off_q;
        n_kij_d  = n_kij_q;
        n_act_d  = n_act_q;
        w_base_d = w_base_q;
        x_base_d = x_base_q;
        p_base_d = p_base_q;
        drain_wr = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    n_kij_d  = bus.cfg_n_kij;
                    n_act_d  = bus.cfg_n_act;
                    w_base_d = bus.cfg_w_base;
                    x_base_d = bus.cfg_x_base;
                    p_base_d = bus.cfg_p_base;
                    cnt_d    = '0;
                    k_d      = '0;
                    kij_d    = '0;
                    w_off_d  = '0;
                    p_off_d  = '0;
                    state_d  = (bus.cfg_n_kij == 4'd0 || bus.cfg_n_act == '0) ? S_FIN : S_WFETCH;
                end
            end
            S_WFETCH: begin
                if (cnt_q == CNT_W'(row)) begin
                    state_d = S_WLOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WLOAD: begin
                if (cnt_q == CNT_W'(row)) begin
                    state_d = S_XFETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_XFETCH: begin
                if (cnt_q == {1'b0, n_act_q}) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_EXEC: begin
                if (cnt_q == exec_last) begin
                    state_d  = S_DRAIN;
                    cnt_d    = '0;
                    drain_wr = bus.ofifo_valid;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // k_q counts writes already issued, including the one on the bus now.
                if (k_q == n_act_q) begin
                    kij_d   = kij_q + 4'd1;
                    w_off_d = w_off_q + addr_w'(row);
                    p_off_d = p_off_q + n_act_q;
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = (kij_q + 4'd1 == n_kij_q) ? S_FIN : S_WFETCH;
                end else begin
                    drain_wr = bus.ofifo_valid;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (drain_wr) begin
            k_d = k_q + 1'b1;
        end
    end

    always_comb begin
        inst_d = IDLE_INST;
        case (state_d)
            S_WFETCH: begin
                if (cnt_d < CNT_W'(row)) begin
                    inst_d.cen_xmem = 1'b0;
                    inst_d.a_xmem   = w_base_d + w_off_d + cnt_d[addr_w-1:0];
                end
                // SRAM data lands one cycle after its address.
                inst_d.l0_wr = (cnt_d != '0);
            end
            S_WLOAD: begin
                inst_d.l0_rd = (cnt_d < CNT_W'(row));
                inst_d.load  = (cnt_d < CNT_W'(row));
            end
            S_XFETCH: begin
                if (cnt_d < {1'b0, n_act_d}) begin
                    inst_d.cen_xmem = 1'b0;
                    inst_d.a_xmem   = x_base_d + cnt_d[addr_w-1:0];
                end
                inst_d.l0_wr = (cnt_d != '0);
            end
            S_EXEC: begin
                inst_d.execute = 1'b1;
                inst_d.l0_rd   = (cnt_d < {1'b0, n_act_d});
                inst_d.acc     = (kij_d != 4'd0);
            end
            S_DRAIN: begin
                if (drain_wr) begin
                    inst_d.ofifo_rd = 1'b1;
                    inst_d.cen_pmem = 1'b0;
                    inst_d.wen_pmem = 1'b0;
                    inst_d.a_pmem   = p_base_d + p_off_d + k_q;
                end
            end
            default: begin
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d = (state_d == S_FIN);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            kij_q    <= '0;
            w_off_q  <= '0;
            p_off_q  <= '0;
            n_kij_q  <= '0;
            n_act_q  <= '0;
            w_base_q <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
            inst_q   <= IDLE_INST;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            kij_q    <= kij_d;
            w_off_q  <= w_off_d;
            p_off_q  <= p_off_d;
            n_kij_q  <= n_kij_d;
            n_act_q  <= n_act_d;
            w_base_q <= w_base_d;
            x_base_q <= x_base_d;
            p_base_q <= p_base_d;
            inst_q   <= inst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.inst  = inst_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.phase = state_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Self-checking bench for core_inst_seq: directed job table with hand-derived
// totals, a cycle-exact trace model, reset/abort sequences and random jobs.
module tb_core_inst_seq;
    localparam int ROW   = 8;
    localparam int FLUSH = 16;
    localparam int MAXC  = 2048;
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

    typedef struct packed {
        int done_cyc;
        int n_load;
        int n_exec;
        int n_acc;
        int n_pwr;
        int last_ap;
        int n_xrd;
        int n_done;
    } stats_t;

    typedef struct packed {
        logic [3:0]  n_kij;
        logic [10:0] n_act;
        logic [10:0] w_base;
        logic [10:0] x_base;
        logic [10:0] p_base;
        int          vmode;
        stats_t      want;
    } vec_t;

    logic clk;
    logic reset_n;

    core_inst_seq_if #(.addr_w(11)) bus ();

    core_inst_seq #(.row(ROW), .col(8), .addr_w(11), .flush(FLUSH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          vpat [MAXC];
    logic [38:0] exp_q [$];
    vec_t        vecs [6];
    string       names [6];

    initial begin
        clk = 1'b0;
        #20;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, want);
    endtask

    function automatic logic [33:0] mk(input bit acc, input bit pw, input logic [10:0] ap,
                                       input bit xr, input logic [10:0] ax, input bit ofrd,
                                       input bit l0rd, input bit l0wr, input bit ex, input bit ld);
        return {acc, ~pw, ~pw, ap, ~xr, 1'b1, ax, ofrd, 1'b0, 1'b0, l0rd, l0wr, ex, ld};
    endfunction

    function automatic void push(input logic [33:0] w, input int ph);
        exp_q.push_back({3'(ph), (ph >= 1 && ph <= 5), (ph == 6), w});
    endfunction

    // Expected per-cycle trace, cycle 0 being the cycle after the start edge.
    // A drain cycle writes when ofifo_valid was high during the previous cycle.
    function automatic void build(input vec_t v);
        int n_act = int'(v.n_act);
        int n_kij = int'(v.n_kij);
        exp_q.delete();
        if (n_kij != 0 && n_act != 0) begin
            for (int kij = 0; kij < n_kij; kij++) begin
                for (int i = 0; i <= ROW; i++)
                    push(mk(1'b0, 1'b0, 11'd0, i < ROW, (i < ROW) ? 11'(int'(v.w_base) + kij*ROW + i) : 11'd0,
                            1'b0, 1'b0, i > 0, 1'b0, 1'b0), 1);
                for (int i = 0; i <= ROW; i++)
                    push(mk(1'b0, 1'b0, 11'd0, 1'b0, 11'd0, 1'b0, i < ROW, 1'b0, 1'b0, i < ROW), 2);
                for (int j = 0; j <= n_act; j++)
                    push(mk(1'b0, 1'b0, 11'd0, j < n_act, (j < n_act) ? 11'(int'(v.x_base) + j) : 11'd0,
                            1'b0, 1'b0, j > 0, 1'b0, 1'b0), 3);
                for (int e = 0; e < n_act + FLUSH; e++)
                    push(mk(kij > 0, 1'b0, 11'd0, 1'b0, 11'd0, 1'b0, e < n_act, 1'b0, 1'b1, 1'b0), 4);
                for (int k = 0; k < n_act; ) begin
                    if (vpat[exp_q.size() - 1]) begin
                        push(mk(1'b0, 1'b1, 11'(int'(v.p_base) + kij*n_act + k), 1'b0, 11'd0,
                                1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 5);
                        k++;
                    end else begin
                        push(IDLE_W, 5);
                    end
                end
            end
        end
        push(IDLE_W, 6);
        push(IDLE_W, 0);
    endfunction

    task automatic run_job(input vec_t v, input string tag, output stats_t s);
        int          n;
        logic [33:0] w;
        for (int c = 0; c < MAXC; c++) begin
            case (v.vmode)
                0:       vpat[c] = 1'b1;
                1:       vpat[c] = (c % 3 == 0);
                default: vpat[c] = (c % 8 == 7) || ($urandom_range(0, 99) < 55);
            endcase
        end
        build(v);
        n = exp_q.size();
        s = '0;
        s.done_cyc = -1;

        @(negedge clk);
        bus.cfg_n_kij   = v.n_kij;
        bus.cfg_n_act   = v.n_act;
        bus.cfg_w_base  = v.w_base;
        bus.cfg_x_base  = v.x_base;
        bus.cfg_p_base  = v.p_base;
        bus.ofifo_valid = 1'b0;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            w = bus.inst;
            check($sformatf("%s cyc%0d {phase,busy,done,inst}", tag, c),
                  64'({bus.phase, bus.busy, bus.done, w}), 64'(exp_q[c]));
            if (bus.done) begin
                s.n_done++;
                if (s.done_cyc < 0) s.done_cyc = c;
            end
            s.n_load += int'(w[0]);
            s.n_exec += int'(w[1]);
            s.n_acc  += int'(w[33]);
            s.n_xrd  += int'(!w[19]);
            if (!w[32] && !w[31]) begin
                s.n_pwr++;
                s.last_ap = int'(w[30:20]);
            end
            // Stray starts and cfg churn mid-job must be ignored.
            bus.ofifo_valid = vpat[c];
            bus.start       = (c < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.cfg_n_kij   = 4'($urandom);
            bus.cfg_n_act   = 11'($urandom);
            bus.cfg_w_base  = 11'($urandom);
            bus.cfg_x_base  = 11'($urandom);
            bus.cfg_p_base  = 11'($urandom);
        end
    endtask

    function automatic vec_t mkvec(input int kij, input int act, input int wb, input int xb,
                                   input int pb, input int vm, input int dc, input int nl,
                                   input int ne, input int na, input int np, input int la, input int nx);
        vec_t v;
        v.n_kij  = 4'(kij);
        v.n_act  = 11'(act);
        v.w_base = 11'(wb);
        v.x_base = 11'(xb);
        v.p_base = 11'(pb);
        v.vmode  = vm;
        v.want.done_cyc = dc;
        v.want.n_load   = nl;
        v.want.n_exec   = ne;
        v.want.n_acc    = na;
        v.want.n_pwr    = np;
        v.want.last_ap  = la;
        v.want.n_xrd    = nx;
        v.want.n_done   = 1;
        return v;
    endfunction

    initial begin
        bit     found;
        int     quiet;
        stats_t s;
        vec_t   v;

        // kij act wbase xbase pbase vmode | done_cyc loads execs accs pwrites last_ap xreads
        vecs[0] = mkvec(1, 4,    0,   64,    0, 0,  47,  8, 20,  0, 4,   3, 12); names[0] = "single";
        vecs[1] = mkvec(3, 2,   16,  100,    0, 0, 123, 24, 54, 36, 6,   5, 30); names[1] = "multi";
        vecs[2] = mkvec(1, 4,    0,   64,  100, 1,  53,  8, 20,  0, 4, 103, 12); names[2] = "stall";
        vecs[3] = mkvec(2, 0,    5,    6,    7, 0,   0,  0,  0,  0, 0,   0,  0); names[3] = "empty_act";
        vecs[4] = mkvec(0, 5,    5,    6,    7, 0,   0,  0,  0,  0, 0,   0,  0); names[4] = "empty_kij";
        vecs[5] = mkvec(1, 4, 2044, 2046, 2046, 0,  47,  8, 20,  0, 4,   1, 12); names[5] = "wrap";

        reset_n         = 1'b1;
        bus.start       = 1'b0;
        bus.cfg_n_kij   = '0;
        bus.cfg_n_act   = '0;
        bus.cfg_w_base  = '0;
        bus.cfg_x_base  = '0;
        bus.cfg_p_base  = '0;
        bus.ofifo_valid = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        check("reset inst",  64'(bus.inst),  64'(IDLE_W));
        check("reset busy",  64'(bus.busy),  64'(0));
        check("reset done",  64'(bus.done),  64'(0));
        check("reset phase", 64'(bus.phase), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Abort a job mid-EXEC: outputs return to idle, no done pulse follows.
        @(negedge clk);
        bus.cfg_n_kij  = 4'd2;
        bus.cfg_n_act  = 11'd3;
        bus.cfg_w_base = 11'd0;
        bus.cfg_x_base = 11'd10;
        bus.cfg_p_base = 11'd20;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = (bus.phase == 3'd4);
        end
        check("abort reached EXEC", 64'(found), 64'(1));
        reset_n = 1'b0;
        #1;
        check("abort async idle", 64'({bus.phase, bus.busy, bus.done, bus.inst}),
              64'({3'd0, 1'b0, 1'b0, IDLE_W}));
        @(posedge clk);
        #1;
        check("abort edge idle", 64'({bus.phase, bus.busy, bus.done, bus.inst}),
              64'({3'd0, 1'b0, 1'b0, IDLE_W}));
        @(negedge clk);
        reset_n = 1'b1;
        quiet = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (!bus.done && bus.phase == 3'd0 && bus.inst == IDLE_W) quiet++;
        end
        check("abort quiet cycles", 64'(quiet), 64'(4));

        for (int t = 0; t < 6; t++) begin
            run_job(vecs[t], names[t], s);
            check({names[t], " done_cyc"}, 64'(s.done_cyc), 64'(vecs[t].want.done_cyc));
            check({names[t], " n_done"},   64'(s.n_done),   64'(vecs[t].want.n_done));
            check({names[t], " n_load"},   64'(s.n_load),   64'(vecs[t].want.n_load));
            check({names[t], " n_exec"},   64'(s.n_exec),   64'(vecs[t].want.n_exec));
            check({names[t], " n_acc"},    64'(s.n_acc),    64'(vecs[t].want.n_acc));
            check({names[t], " n_pwr"},    64'(s.n_pwr),    64'(vecs[t].want.n_pwr));
            check({names[t], " last_ap"},  64'(s.last_ap),  64'(vecs[t].want.last_ap));
            check({names[t], " n_xrd"},    64'(s.n_xrd),    64'(vecs[t].want.n_xrd));
        end

        for (int r = 0; r < 10; r++) begin
            v = '0;
            v.n_kij  = 4'($urandom_range(0, 3));
            v.n_act  = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom_range(1, 6));
            v.w_base = 11'($urandom);
            v.x_base = 11'($urandom);
            v.p_base = 11'($urandom);
            v.vmode  = 2;
            run_job(v, $sformatf("rand%0d", r), s);
            check($sformatf("rand%0d n_done", r), 64'(s.n_done), 64'(1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
